alu_issue_ctrl: RTL
===================

# alu_issue_ctrl

Issue controller driving the team ALU (16-bit operands, 3-bit opcode, mode select, 32-bit result, za/zb/eq/gt/lt flags) from the initiator side. It has the following parts:
- An instruction port with a valid/ready handshake.
- An 8×16 operand register file.
- A result port that returns the 32-bit ALU output, the five flags and the destination tag.

It sits between the host/program source and the combinational ALU, and is the sequential front end for that ALU.

## Interface
- ALU_WAIT, default 1: ALU settle cycles in EXEC. Legal range 1..15.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- instr_valid  input  1  instruction offered.
- instr_ready  output  1  controller can accept; high only in IDLE.
- instr  input  13  instruction fields:
  - [12] mode
  - [11:9] opcode
  - [8:6] rd
  - [5:3] rs1
  - [2:0] rs2
- wr_en  input  1  host register write strobe.
- wr_addr  input  3  host write address.
- wr_data  input  16  host write data.
- alu_a  output  16  ALU operand a (rs1 value).
- alu_b  output  16  ALU operand b (rs2 value).
- alu_opcode  output  3  ALU opcode.
- alu_mode  output  1  ALU mode (0 arithmetic, 1 logic).
- alu_out  input  32  ALU result.
- alu_flags  input  5  ALU flags {za, zb, eq, gt, lt}.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- res_data  output  32  captured alu_out.
- res_flags  output  5  captured {za, zb, eq, gt, lt}.
- res_rd  output  3  rd of the completed instruction.

## Operation
- FSM states and transitions:
  - IDLE → READ on instr_valid & instr_ready. The fields are latched on that edge.
  - READ → EXEC after 1 cycle. The register file is read into the a/b holding registers.
  - EXEC stays for ALU_WAIT cycles, counted by a 4-bit down-counter. On its last edge: alu_out → res_data, alu_flags → res_flags, res_rd ← rd, then → RESP.
  - RESP → IDLE on res_valid & res_ready.
- ALU drive:
  - alu_a, alu_b, alu_opcode and alu_mode come straight from the holding registers.
  - They change only on the READ edge and stay stable through EXEC and RESP until the next READ.
- Host writes: wr_en writes wr_data to wr_addr on any cycle, in any state.
- Read timing: a host write in the READ cycle to rs1/rs2 is not seen; the old value is used because the read and write happen on the same edge.
- rs1 == rs2 is legal; both operands get the same value.
- instr_valid outside IDLE is ignored; instr_ready is low and nothing is latched.
- res_data, res_flags and res_rd hold stable while res_valid is high and res_ready is low.
- Reset values:
  - All outputs 0, register file cleared to 0, FSM in IDLE.
  - After reset deasserts, instr_ready goes to 1 in the first cycle in IDLE.
- Reset mid-operation: the in-flight instruction is dropped, no writeback happens, and res_valid clears immediately (asynchronous).

## Timing
- Accept edge E0. Operands latched at E1. Capture at E(1+ALU_WAIT).
- res_valid goes high in the cycle after edge E(1+ALU_WAIT). With the default ALU_WAIT = 1 this is 3 cycles after accept.
- With res_ready held high, RESP lasts one cycle. Instruction period is 3+ALU_WAIT cycles, i.e. 4 at the default.
- Result hold: res_valid stays asserted until the handshake edge and drops on the following cycle.

## Configuration
- ALU_ISSUE_WRITEBACK_EN defined:
  - On the capture edge, alu_out[15:0] is also written to register rd.
  - If a host write hits the same address on the same edge, the writeback wins and the host write is dropped.
  - A host write to a different address on that edge completes normally.
- ALU_ISSUE_WRITEBACK_EN undefined: the register file is written only by the host port, and rd is only reported on res_rd.

## Test plan
The bench uses a stub ALU:
- alu_out = {alu_a, alu_b}
- za = (a == 0), zb = (b == 0), eq = (a == b), gt = (a > b), lt = (a < b)

Scenarios:
- Reset, then host writes r1 = 0x0003 and r2 = 0x000F. Issue mode 1, opcode 3, rd 4, rs1 1, rs2 2 → alu_mode = 1 and alu_opcode = 3 from the READ edge. Three cycles after accept: res_data = 0x0003000F, res_flags = 5'b00001, res_rd = 4.
- res_ready held low for 5 cycles → res_valid and res_data stable, instr_ready stays 0, and a new instr_valid is not accepted.
- r5 = r6 = 0x00E9, issue rs1 5, rs2 6 → res_flags = 5'b00100. Then rs1 0, rs2 0 (registers cleared at reset) → res_flags = 5'b11100.
- With ALU_WAIT = 4 → res_valid rises 6 cycles after accept, and alu_a stays stable for the full EXEC period.
- With the macro defined:
  - rd = 1 writes 0x000F back into r1 (alu_out = 0x0003000F).
  - A simultaneous host write to r1 is dropped, and r1 reads 0x000F.
  - Without the macro, r1 keeps its host value.
- Reset asserted during EXEC → all outputs 0 immediately, no writeback, FSM returns to IDLE.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Sequential issue front end for the team's combinational ALU. A host offers
// 13-bit instructions over a valid/ready handshake. The controller reads two
// operands from an 8 x 16 register file and drives them to the ALU. After the
// ALU has had ALU_WAIT cycles to settle, it captures the result and flags and
// presents them, with the destination tag, on a valid/ready result port.
//
// Parameters
//   ALU_WAIT      ALU settle cycles spent in EXEC (legal range 1..15).
//
// Optional feature (compile-time macro)
//   ALU_ISSUE_WRITEBACK_EN
//     Defined:   on the capture edge alu_out[15:0] is also written to register
//                rd. A host write to the same address on that edge is dropped.
//     Undefined: only the host port writes the register file. rd is reported
//                on res_rd and has no other effect.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   instr_valid     instruction offered by the host
//   instr_ready     controller can accept (IDLE only)
//   instr[12:0]     {mode, opcode[2:0], rd[2:0], rs1[2:0], rs2[2:0]}
//   wr_en           host register write strobe (honoured in any state)
//   wr_addr[2:0]    host write address
//   wr_data[15:0]   host write data
//   alu_a, alu_b    operands to the ALU (rs1 / rs2 values)
//   alu_opcode      ALU opcode
//   alu_mode        ALU mode (0 arithmetic, 1 logic)
//   alu_out[31:0]   ALU result
//   alu_flags[4:0]  ALU flags {za, zb, eq, gt, lt}
//   res_valid       captured result available
//   res_ready       consumer accepts the result
//   res_data        captured alu_out
//   res_flags       captured alu_flags
//   res_rd          destination tag of the completed instruction
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int ALU_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [12:0] instr,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [15:0] wr_data,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_opcode,
  output logic        alu_mode,
  input  logic [31:0] alu_out,
  input  logic [4:0]  alu_flags,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [4:0]  res_flags,
  output logic [2:0]  res_rd
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_t;

  // The counter is loaded on entry to EXEC and the capture happens on the edge
  // where it reads zero, so loading ALU_WAIT-1 gives exactly ALU_WAIT cycles.
  localparam logic [3:0] WAIT_LOAD = 4'(ALU_WAIT - 1);

  state_t      state;
  state_t      state_next;

  logic        accept;
  logic        load_ops;
  logic        capture;
  logic        release_res;

  logic [3:0]  wait_cnt;

  logic [15:0] regs [8];

  // Instruction fields as latched at accept time.
  logic        mode_q;
  logic [2:0]  opcode_q;
  logic [2:0]  rd_q;
  logic [2:0]  rs1_q;
  logic [2:0]  rs2_q;

  // Ready is gated by reset so every output reads zero while reset is held,
  // and rises in the first IDLE cycle after release.
  assign instr_ready = (state == IDLE) & ~rst;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus the one-cycle strobes that steer the datapath.
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    load_ops    = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    case (state)
      IDLE: begin
        if (instr_valid) begin
          accept     = 1'b1;
          state_next = READ;
        end
      end
      READ: begin
        load_ops   = 1'b1;
        state_next = EXEC;
      end
      EXEC: begin
        if (wait_cnt == 4'd0) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (res_valid && res_ready) begin
          release_res = 1'b1;
          state_next  = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Latch the instruction fields on the accept edge only, so instr_valid
  // offered outside IDLE never disturbs an instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= 1'b0;
      opcode_q <= 3'd0;
      rd_q     <= 3'd0;
      rs1_q    <= 3'd0;
      rs2_q    <= 3'd0;
    end else if (accept) begin
      mode_q   <= instr[12];
      opcode_q <= instr[11:9];
      rd_q     <= instr[8:6];
      rs1_q    <= instr[5:3];
      rs2_q    <= instr[2:0];
    end
  end

  // EXEC dwell counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 4'd0;
    end else if (load_ops) begin
      wait_cnt <= WAIT_LOAD;
    end else if (state == EXEC && wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Operand holding registers. They drive the ALU directly and change only on
  // the READ edge. A host write on that same edge is not visible here because
  // the array still holds its pre-edge contents when it is sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a      <= 16'd0;
      alu_b      <= 16'd0;
      alu_opcode <= 3'd0;
      alu_mode   <= 1'b0;
    end else if (load_ops) begin
      alu_a      <= regs[rs1_q];
      alu_b      <= regs[rs2_q];
      alu_opcode <= opcode_q;
      alu_mode   <= mode_q;
    end
  end

  // Register file. The writeback assignment comes after the host write, so
  // when both target the same address on the capture edge the writeback wins.
  // A host write to any other address still lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= 16'd0;
      end
    end else begin
      if (wr_en) begin
        regs[wr_addr] <= wr_data;
      end
`ifdef ALU_ISSUE_WRITEBACK_EN
      if (capture) begin
        regs[rd_q] <= alu_out[15:0];
      end
`endif
    end
  end

  // Result capture and handshake. The payload is written only on the capture
  // edge, so it holds steady for as long as the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= 32'd0;
      res_flags <= 5'd0;
      res_rd    <= 3'd0;
    end else if (capture) begin
      res_valid <= 1'b1;
      res_data  <= alu_out;
      res_flags <= alu_flags;
      res_rd    <= rd_q;
    end else if (release_res) begin
      res_valid <= 1'b0;
    end
  end

endmodule
